uart_rx_framer: RTL and testbench

Receive-side UART for the board RS232 port. It deserialises bytes arriving on UART_RXD, so the game logic can take moves ('R'/'P'/'S') from a host PC while the processor system drives UART_TXD. It uses a 16x oversampled receiver and a one-entry holding register with a valid/ready handshake toward the game FSM, and reports framing, parity and overrun errors.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_framer.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_framer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the RS232 UART blocks.
// Holds the receiver state encoding, parity modes and the oversampling divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Rounded clocks per 1/16-bit tick.
    function automatic int calc_os_div(input int clk_hz, input int baud);
        return (clk_hz + baud * 8) / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks.
// A synchronous restart realigns the phase to the current edge.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_framer.sv
// 16x oversampled UART receiver with a one-entry holding register.
// Delivers every frame, including errored ones, and flags framing, parity and overrun errors.
module uart_rx_framer #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int OS_DIV    = uart_pkg::calc_os_div(CLK_HZ, BAUD)
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    import uart_pkg::*;

    logic       rxd_meta;
    logic       rxd_s;
    state_t     state;
    state_t     state_next;
    logic       tick;
    logic       restart;
    logic       at_point;
    logic       frame_done;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       par_bit;
    logic       par_err_c;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= UART_RXD;
            rxd_s    <= rxd_meta;
        end
    end

    uart_baud_tick #(.DIV(OS_DIV)) u_tick (
        .clock   (CLOCK_50),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // START samples at mid-bit (8 ticks); every later bit is a full 16 ticks on.
    assign at_point = tick && (tick_cnt == ((state == START) ? 4'd7 : 4'd15));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_next = START;
                    restart    = 1'b1;
                end
            end
            START: begin
                if (at_point) begin
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_point && bit_idx == 3'(DATA_BITS - 1)) begin
                    state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end
            end
            uart_pkg::PARITY: begin
                if (at_point) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (at_point) begin
                    frame_done = 1'b1;
                    state_next = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (restart || at_point) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if (state == START) begin
                bit_idx <= '0;
                shreg   <= '0;
            end else if (state == DATA && at_point) begin
                bit_idx        <= bit_idx + 3'd1;
                shreg[bit_idx] <= rxd_s;
            end
            if (state == uart_pkg::PARITY && at_point) begin
                par_bit <= rxd_s;
            end
        end
    end

    // Odd parity expects the data+parity XOR to be 1, even expects 0.
    assign par_err_c = (PARITY != PAR_NONE) &&
                       ((^shreg ^ par_bit) != (PARITY == PAR_ODD));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid      <= 1'b1;
                    rx_data       <= shreg;
                    rx_frame_err  <= !rxd_s;
                    rx_parity_err <= par_err_c;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (rx_valid && rx_ready) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: a default no-parity instance at 432 clocks/bit
// and a fast even-parity instance at 32 clocks/bit sharing clock and reset.
module tb_uart_rx_framer;

    localparam int BIT0 = 432;
    localparam int BIT1 = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rxReady = 1'b0;
    logic [7:0] rxData;
    logic       rxValid, rxFrameErr, rxParityErr, rxOverrun, rxBusy;
    logic       rxd2 = 1'b1;
    logic       rxReady2 = 1'b0;
    logic [7:0] rxData2;
    logic       rxValid2, rxFrameErr2, rxParityErr2, rxOverrun2, rxBusy2;

    int checkCount = 0;
    int passCount  = 0;

    always #10 clock = ~clock;

    uart_rx_framer dut (
        .CLOCK_50      (clock),
        .reset         (reset),
        .UART_RXD      (rxd),
        .rx_data       (rxData),
        .rx_valid      (rxValid),
        .rx_ready      (rxReady),
        .rx_frame_err  (rxFrameErr),
        .rx_parity_err (rxParityErr),
        .rx_overrun    (rxOverrun),
        .rx_busy       (rxBusy)
    );

    uart_rx_framer #(.BAUD(1562500), .PARITY(2)) dutPar (
        .CLOCK_50      (clock),
        .reset         (reset),
        .UART_RXD      (rxd2),
        .rx_data       (rxData2),
        .rx_valid      (rxValid2),
        .rx_ready      (rxReady2),
        .rx_frame_err  (rxFrameErr2),
        .rx_parity_err (rxParityErr2),
        .rx_overrun    (rxOverrun2),
        .rx_busy       (rxBusy2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic driveBit(input int sel, input logic b);
        if (sel == 0) begin
            rxd = b;
            repeat (BIT0) @(negedge clock);
        end else begin
            rxd2 = b;
            repeat (BIT1) @(negedge clock);
        end
    endtask

    // Called on a negedge; returns on the negedge that ends the stop bit.
    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic usePar,
                                 input logic parBit, input logic stopBit);
        driveBit(sel, 1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(sel, data[i]);
        end
        if (usePar) begin
            driveBit(sel, parBit);
        end
        driveBit(sel, stopBit);
    endtask

    task automatic pulseReady(input int sel);
        if (sel == 0) rxReady = 1'b1;
        else          rxReady2 = 1'b1;
        @(negedge clock);
        rxReady  = 1'b0;
        rxReady2 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("reset_flags", {rxValid, rxFrameErr, rxParityErr, rxOverrun, rxBusy}, 5'b0);
        checkOutput("reset_data", rxData, 8'h00);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        $display("[TB] basic receive 0x52");
        applyStimulus(0, 8'h52, 1'b0, 1'b0, 1'b1);
        checkOutput("r_valid", rxValid, 1);
        checkOutput("r_data", rxData, 8'h52);
        checkOutput("r_errs", {rxFrameErr, rxParityErr, rxOverrun}, 3'b000);
        pulseReady(0);
        checkOutput("r_consumed", rxValid, 0);
        checkOutput("r_data_hold", rxData, 8'h52);

        $display("[TB] start glitch");
        rxd = 1'b0;
        repeat (3) @(negedge clock);
        rxd = 1'b1;
        repeat (147) @(negedge clock);
        checkOutput("glitch_busy", rxBusy, 1);
        repeat (150) @(negedge clock);
        checkOutput("glitch_idle", {rxBusy, rxValid}, 2'b00);

        $display("[TB] framing error and held-low line");
        applyStimulus(0, 8'h53, 1'b0, 1'b0, 1'b0);
        checkOutput("fe_valid", rxValid, 1);
        checkOutput("fe_data", rxData, 8'h53);
        checkOutput("fe_flag", rxFrameErr, 1);
        checkOutput("fe_break_busy", rxBusy, 1);
        pulseReady(0);
        repeat (2000) @(negedge clock);
        checkOutput("fe_no_refire", {rxValid, rxBusy}, 2'b01);
        checkOutput("fe_flag_hold", rxFrameErr, 1);
        rxd = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("fe_release", {rxValid, rxBusy}, 2'b00);

        $display("[TB] even parity");
        applyStimulus(1, 8'h50, 1'b1, 1'b1, 1'b1);
        checkOutput("par_bad_valid", rxValid2, 1);
        checkOutput("par_bad_data", rxData2, 8'h50);
        checkOutput("par_bad_flag", {rxParityErr2, rxFrameErr2}, 2'b10);
        pulseReady(1);
        applyStimulus(1, 8'h50, 1'b1, 1'b0, 1'b1);
        checkOutput("par_ok_valid", rxValid2, 1);
        checkOutput("par_ok_flag", {rxParityErr2, rxFrameErr2}, 2'b00);
        pulseReady(1);

        $display("[TB] overrun");
        applyStimulus(0, 8'h52, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 8'h50, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_data", rxData, 8'h52);
        checkOutput("ovr_flags", {rxValid, rxOverrun, rxFrameErr}, 3'b110);
        pulseReady(0);
        checkOutput("ovr_cleared", {rxValid, rxOverrun}, 2'b00);

        $display("[TB] transfer coinciding with completion");
        applyStimulus(0, 8'h52, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 8'h50, 1'b0, 1'b0, 1'b1);
        checkOutput("co_pre_ovr", rxOverrun, 1);
        fork
            applyStimulus(0, 8'h53, 1'b0, 1'b0, 1'b1);
            begin
                // Stop-bit mid-sample lands on the 4107th rising edge after the start edge.
                repeat (4106) @(posedge clock);
                @(negedge clock);
                checkOutput("co_before", {rxValid, rxData}, {1'b1, 8'h52});
                rxReady = 1'b1;
                @(negedge clock);
                rxReady = 1'b0;
                checkOutput("co_data", rxData, 8'h53);
                checkOutput("co_flags", {rxValid, rxOverrun}, 2'b10);
                @(negedge clock);
                checkOutput("co_valid_hold", rxValid, 1);
            end
        join

        $display("[TB] reset mid-frame");
        driveBit(0, 1'b0);
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        checkOutput("rst_pre_busy", rxBusy, 1);
        reset = 1'b1;
        rxd   = 1'b1;
        @(negedge clock);
        checkOutput("rst_flags", {rxValid, rxFrameErr, rxParityErr, rxOverrun, rxBusy}, 5'b0);
        checkOutput("rst_data", rxData, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (500) @(negedge clock);
        checkOutput("rst_nothing", {rxValid, rxBusy}, 2'b00);
        applyStimulus(0, 8'h50, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_next_frame", {rxValid, rxData}, {1'b1, 8'h50});
        checkOutput("rst_next_errs", {rxFrameErr, rxParityErr, rxOverrun}, 3'b000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
